// File: rtl/vs_mem_pkg.sv
// vs_mem_pkg: shared types and helpers for the arbitrated synchronous RAM slice
package vs_mem_pkg;
  localparam int VS_NUM_PORTS = 4;
  typedef logic [$clog2(VS_NUM_PORTS)-1:0] vs_port_idx_t;
  typedef enum logic {VS_MEM_READ, VS_MEM_WRITE} vs_mem_op_e;
  function automatic int vs_next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/vs_round_robin_arbiter.sv
// vs_round_robin_arbiter: circular-priority one-hot grant with a rotating pointer
module vs_round_robin_arbiter
  import vs_mem_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] j;
  // Scan from farthest to nearest so the nearest requester wins the last write
  always_comb begin
    grant = '0;
    index = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (reset_n && req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        index = j;
      end
    end
  end
  always_ff @(posedge clock)
    if (!reset_n) ptr <= '0;
    else if (accept) ptr <= IW'(vs_next_index(int'(index), N));
endmodule

// File: rtl/vs_sync_ram_arbiter.sv
// vs_sync_ram_arbiter: round-robin sharing of one sync RAM with per-port read responses
module vs_sync_ram_arbiter
  import vs_mem_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  localparam int IW = $clog2(NUM_PORTS)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            ram_write_enable,
  output logic [ADDR_WIDTH-1:0]           ram_write_addr,
  output logic [ADDR_WIDTH-1:0]           ram_read_addr,
  output logic [DATA_WIDTH-1:0]           ram_in_data,
  input  logic [DATA_WIDTH-1:0]           ram_out_data
);
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] rsp_idx;
  logic          accept;
  logic          rsp_pend;
  vs_mem_op_e    op;
  vs_round_robin_arbiter #(.N(NUM_PORTS)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req_valid),
    .accept  (accept),
    .grant   (req_ready),
    .index   (grant_idx)
  );
  // Idle cycles leave grant_idx at 0, so the RAM sees port-0 fields
  assign accept           = |(req_valid & req_ready);
  assign op               = req_write[grant_idx] ? VS_MEM_WRITE : VS_MEM_READ;
  assign ram_write_addr   = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_read_addr    = ram_write_addr;
  assign ram_in_data      = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign ram_write_enable = accept && op == VS_MEM_WRITE;
  assign rsp_data         = ram_out_data;
  always_ff @(posedge clock)
    if (!reset_n) begin
      rsp_pend <= 1'b0;
      rsp_idx  <= '0;
    end else begin
      rsp_pend <= accept && op == VS_MEM_READ;
      if (accept) rsp_idx <= grant_idx;
    end
  always_comb begin
    rsp_valid = '0;
    rsp_valid[rsp_idx] = rsp_pend && reset_n;
  end
endmodule

// File: tb/tb_vs_sync_ram_arbiter.sv
// tb_vs_sync_ram_arbiter: directed and randomized checks against a behavioural model
module tb_vs_sync_ram_arbiter;
  localparam int NP = 4, DW = 8, AW = 16;
  logic clock = 0, reset_n = 0;
  logic [NP-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_data, ram_in_data, ram_out_data;
  logic ram_write_enable;
  logic [AW-1:0] ram_write_addr, ram_read_addr;
  logic [DW-1:0] ram_mem [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  int n_cmp = 0, n_bad = 0;
  int m_ptr = 0, m_pend_port = 0, cur_g = -1;
  bit m_pend = 0, cur_wr = 0;
  logic [DW-1:0] m_pend_data = '0, cur_wdata = '0;
  logic [AW-1:0] cur_addr = '0;
  logic [NP-1:0] acc_mask = '0;

  always #5 clock = ~clock;

  vs_sync_ram_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ram_write_enable(ram_write_enable),
    .ram_write_addr(ram_write_addr), .ram_read_addr(ram_read_addr),
    .ram_in_data(ram_in_data), .ram_out_data(ram_out_data)
  );

  // Synchronous RAM, registered read returning old data on collision
  always @(posedge clock) begin
    if (ram_write_enable) ram_mem[ram_write_addr] <= ram_in_data;
    ram_out_data <= ram_mem[ram_read_addr];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model evaluated mid-cycle from current inputs and model state
  always @(negedge clock) begin
    int g, sel;
    g = -1;
    if (reset_n)
      for (int k = 0; k < NP; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
    sel = (g < 0) ? 0 : g;
    cur_g = g;
    cur_wr = (g >= 0) && req_write[sel];
    cur_addr = req_addr[sel*AW +: AW];
    cur_wdata = req_wdata[sel*DW +: DW];
    chk("req_ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
    chk("ram_we", 32'(ram_write_enable), 32'(cur_wr));
    chk("ram_waddr", 32'(ram_write_addr), 32'(cur_addr));
    chk("ram_raddr", 32'(ram_read_addr), 32'(cur_addr));
    chk("ram_wdata", 32'(ram_in_data), 32'(cur_wdata));
    chk("rsp_valid", 32'(rsp_valid), (m_pend && reset_n) ? (1 << m_pend_port) : 0);
    if (m_pend && reset_n) chk("rsp_data", 32'(rsp_data), 32'(m_pend_data));
  end

  always @(posedge clock) begin
    acc_mask = '0;
    m_pend = 0;
    if (!reset_n) m_ptr = 0;
    else if (cur_g >= 0) begin
      acc_mask[cur_g] = 1'b1;
      m_ptr = (cur_g + 1) % NP;
      if (cur_wr) ref_mem[cur_addr] = cur_wdata;
      else begin
        m_pend = 1;
        m_pend_port = cur_g;
        m_pend_data = ref_mem[cur_addr];
      end
    end
  end

  task automatic setp(int p, bit v, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[p] = v;
    req_write[p] = w;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  task automatic nxt;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all;
    for (int p = 0; p < NP; p++) setp(p, 0, 0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    bit found;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      ram_mem[i] = DW'(8'h10 + i);
      ref_mem[i] = DW'(8'h10 + i);
    end
    for (int p = 0; p < NP; p++) setp(p, 1, 1, AW'(p), 8'hEE);
    repeat (3) begin
      @(negedge clock);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_we", 32'(ram_write_enable), 0);
      chk("rst_rsp", 32'(rsp_valid), 0);
      nxt();
    end
    reset_n = 1;
    for (int p = 0; p < NP; p++) setp(p, 1, 0, AW'(p), '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("rot_ready", 32'(req_ready), 1 << (k % 4));
      if (k > 0) begin
        chk("rot_rsp", 32'(rsp_valid), 1 << ((k - 1) % 4));
        chk("rot_data", 32'(rsp_data), 32'h10 + (k - 1) % 4);
      end
      nxt();
    end
    idle_all();
    setp(1, 1, 1, 16'h0010, 8'hA5);
    @(negedge clock);
    chk("wr_ready", 32'(req_ready), 32'b0010);
    chk("wr_we", 32'(ram_write_enable), 1);
    nxt();
    idle_all();
    setp(2, 1, 0, 16'h0010, '0);
    @(negedge clock);
    chk("rd_ready", 32'(req_ready), 32'b0100);
    nxt();
    idle_all();
    @(negedge clock);
    chk("wr_rd_rsp", 32'(rsp_valid), 32'b0100);
    chk("wr_rd_data", 32'(rsp_data), 32'hA5);
    nxt();
    setp(0, 1, 0, '0, '0);
    nxt();
    setp(3, 1, 0, 16'h0003, '0);
    found = 0;
    c = 0;
    while (!found && c < NP) begin
      @(negedge clock);
      found = req_ready[3];
      c++;
      nxt();
    end
    chk("fair_port3", 32'(found), 1);
    setp(3, 0, 0, '0, '0);
    @(negedge clock);
    chk("wrap_ready", 32'(req_ready), 32'b0001);
    nxt();
    setp(0, 1, 1, 16'h0005, 8'h3C);
    nxt();
    setp(0, 1, 0, 16'h0005, '0);
    nxt();
    setp(0, 1, 1, 16'h0005, 8'hC3);
    @(negedge clock);
    chk("b2b_rsp1", 32'(rsp_valid), 32'b0001);
    chk("b2b_data1", 32'(rsp_data), 32'h3C);
    nxt();
    setp(0, 1, 0, 16'h0005, '0);
    nxt();
    idle_all();
    @(negedge clock);
    chk("b2b_rsp2", 32'(rsp_valid), 32'b0001);
    chk("b2b_data2", 32'(rsp_data), 32'hC3);
    nxt();
    setp(2, 1, 0, 16'h0002, '0);
    @(negedge clock);
    chk("mid_ready", 32'(req_ready), 32'b0100);
    nxt();
    reset_n = 0;
    idle_all();
    @(negedge clock);
    chk("mid_rsp", 32'(rsp_valid), 0);
    nxt();
    reset_n = 1;
    for (int p = 0; p < NP; p++) setp(p, 1, 0, AW'(p), '0);
    @(negedge clock);
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    nxt();
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 39) != 0);
      for (int p = 0; p < NP; p++)
        if (!(req_valid[p] && !acc_mask[p]))
          setp(p, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 15)), DW'($urandom));
      nxt();
    end
    reset_n = 1;
    idle_all();
    nxt();
    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vs_sync_ram_arbiter.md
Name: vs_sync_ram_arbiter

Overview:
- Round-robin arbiter that shares one single-clock synchronous RAM (1-cycle registered read, old-data-on-collision) between NUM_PORTS requesters.
- Each requester issues read or write commands over a valid/ready handshake. Read data returns on a per-port response strobe one cycle after acceptance.
- Sits between the RAM instance and client engines (e.g. sparse-vector fetch units); at most one RAM operation per cycle.

Parameters:
- NUM_PORTS, 4, number of requesters (≥2)
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 16, RAM address width

Ports:
- clock  input  1  single clock; all logic on posedge clock
- reset_n  input  1  synchronous, active-low reset
- req_valid  input  NUM_PORTS  per-port command valid
- req_write  input  NUM_PORTS  per-port op: 1=write, 0=read
- req_addr  input  NUM_PORTS*ADDR_WIDTH  packed addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  input  NUM_PORTS*DATA_WIDTH  packed write data; same packing
- req_ready  output  NUM_PORTS  one-hot grant; command i accepted when req_valid[i] & req_ready[i]
- rsp_valid  output  NUM_PORTS  one-hot read-response strobe, 1 cycle
- rsp_data  output  DATA_WIDTH  read data, valid when any rsp_valid bit is set
- ram_write_enable  output  1  to RAM write_enable
- ram_write_addr  output  ADDR_WIDTH  to RAM write_addr
- ram_read_addr  output  ADDR_WIDTH  to RAM read_addr
- ram_in_data  output  DATA_WIDTH  to RAM in_data
- ram_out_data  input  DATA_WIDTH  from RAM out_data

Behaviour:
- Reset (reset_n low at posedge):
  - priority pointer ← 0; rsp_valid register ← 0; response port-id register ← 0.
  - While reset_n is low, req_ready = 0 and ram_write_enable = 0, combinationally gated.
- Grant (combinational from req_valid and pointer): lowest index i ≥ pointer (circular) with req_valid[i]=1 gets req_ready[i]=1. Otherwise all zero.
- Grant-path rules:
  - req_ready never depends on req_write, req_addr or req_wdata.
  - Requesters hold command fields stable while valid and not accepted.
- Pointer update on acceptance of port g: pointer ← (g+1) mod NUM_PORTS. Pointer unchanged on idle cycles.
- Fairness: a continuously asserted req_valid[i] is accepted within NUM_PORTS cycles.
- RAM drive (combinational, same cycle as acceptance):
  - ram_read_addr = ram_write_addr = granted req_addr.
  - ram_in_data = granted req_wdata.
  - ram_write_enable = accept & req_write[g].
  - When idle, addresses and data hold the port-0 fields; ram_write_enable = 0.
- Read response:
  - On read acceptance at edge N, rsp_valid[g] = 1 during cycle N+1 only.
  - rsp_data = ram_out_data (pass-through, no extra register). Total read latency is 1 cycle.
  - Writes produce no response.
- Throughput: one command per cycle, back-to-back, any mix. A read accepted the cycle after a write to the same address returns the new data.
- Boundary cases:
  - Pointer wraps NUM_PORTS-1 → 0.
  - All-ports-valid yields strict rotation 0,1,2,…
  - Single active port is granted every cycle regardless of pointer.
  - Reset asserted at the edge following a read acceptance: rsp_valid stays 0. No write is issued while reset_n is low.
  - rsp_data when no rsp_valid bit is set: don't-care.

Decomposition:
- Package vs_mem_pkg: port-index typedef (width $clog2(NUM_PORTS)), op enum {VS_MEM_READ, VS_MEM_WRITE}, helper function for circular next-index.
- Sub-module vs_round_robin_arbiter (req vector, accept, clock, reset_n → one-hot grant, encoded index). Holds the pointer register, so it is reusable for other shared resources.
- Top level: mux, RAM drive, response register.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with all req_valid=1 → req_ready=0, ram_write_enable=0, rsp_valid=0; first grant after release goes to port 0.
- Write then read: port 1 writes addr 0x0010 data 0xA5; next cycle port 2 reads 0x0010 → rsp_valid=4'b0100 one cycle later, rsp_data=0xA5.
- Rotation: all 4 ports hold reads to addrs 0,1,2,3 (pre-loaded 0x10..0x13) → grants 0,1,2,3,0… on consecutive cycles; responses 0x10,0x11,0x12,0x13 on matching one-hot rsp_valid.
- Fairness: port 0 valid every cycle, port 3 asserts once → port 3 accepted within ≤4 cycles; pointer wraps 3→0.
- Back-to-back mix: port 0 writes 0x0005←0x3C, reads 0x0005, writes 0x0005←0xC3, reads 0x0005 on 4 consecutive cycles → responses 0x3C then 0xC3.
- Reset mid-read: accept read on port 2, drop reset_n at the next edge → rsp_valid stays 0; pointer is 0 after release.
